// File: rtl/mcpu_core_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mcpu_core_wb_stage_if
// Upstream-facing bundle of the write-back stage.
//   mem2wb_*      : four-lane result bundle from the memory stage (+ valid)
//   wb2mem_stall  : back-pressure to the memory stage
//   lr_*          : long-latency return channel (valid/ready handshake)
// master = the producer side (memory stage / long-latency units)
// slave  = the write-back stage
// ---------------------------------------------------------------------------
interface mcpu_core_wb_stage_if;
  logic        mem2wb_valid;
  logic [4:0]  mem2wb_rd_num0;
  logic [4:0]  mem2wb_rd_num1;
  logic [4:0]  mem2wb_rd_num2;
  logic [4:0]  mem2wb_rd_num3;
  logic [31:0] mem2wb_rd_data0;
  logic [31:0] mem2wb_rd_data1;
  logic [31:0] mem2wb_rd_data2;
  logic [31:0] mem2wb_rd_data3;
  logic        mem2wb_rd_we0;
  logic        mem2wb_rd_we1;
  logic        mem2wb_rd_we2;
  logic        mem2wb_rd_we3;
  logic        mem2wb_pred_we0;
  logic        mem2wb_pred_we1;
  logic        mem2wb_pred_we2;
  logic        mem2wb_pred_we3;
  logic        wb2mem_stall;
  logic        lr_valid;
  logic [4:0]  lr_rd_num;
  logic [31:0] lr_rd_data;
  logic        lr_pred;
  logic        lr_ready;

  modport master (
    output mem2wb_valid,
    output mem2wb_rd_num0, mem2wb_rd_num1, mem2wb_rd_num2, mem2wb_rd_num3,
    output mem2wb_rd_data0, mem2wb_rd_data1, mem2wb_rd_data2, mem2wb_rd_data3,
    output mem2wb_rd_we0, mem2wb_rd_we1, mem2wb_rd_we2, mem2wb_rd_we3,
    output mem2wb_pred_we0, mem2wb_pred_we1, mem2wb_pred_we2, mem2wb_pred_we3,
    input  wb2mem_stall,
    output lr_valid, lr_rd_num, lr_rd_data, lr_pred,
    input  lr_ready
  );

  modport slave (
    input  mem2wb_valid,
    input  mem2wb_rd_num0, mem2wb_rd_num1, mem2wb_rd_num2, mem2wb_rd_num3,
    input  mem2wb_rd_data0, mem2wb_rd_data1, mem2wb_rd_data2, mem2wb_rd_data3,
    input  mem2wb_rd_we0, mem2wb_rd_we1, mem2wb_rd_we2, mem2wb_rd_we3,
    input  mem2wb_pred_we0, mem2wb_pred_we1, mem2wb_pred_we2, mem2wb_pred_we3,
    output wb2mem_stall,
    input  lr_valid, lr_rd_num, lr_rd_data, lr_pred,
    output lr_ready
  );
endinterface

// File: rtl/mcpu_core_wb_stage.sv
// ---------------------------------------------------------------------------
// mcpu_core_wb_stage
// Write-back stage: registers the four-lane result bundle towards the
// register file and merges long-latency returns into lane 3 through a
// two-entry return FIFO. A starvation counter forces a one-cycle upstream
// stall so a waiting return is never blocked forever.
// Ports:
//   clkrst_core_clk / clkrst_core_rst : clock, synchronous active-high reset
//   wb_if (slave)                     : mem2wb bundle, stall, lr_* channel
//   wb2rf_*                           : registered register-file write ports
// ---------------------------------------------------------------------------
module mcpu_core_wb_stage (
  input  logic                        clkrst_core_clk,
  input  logic                        clkrst_core_rst,
  mcpu_core_wb_stage_if.slave         wb_if,
  output logic [4:0]                  wb2rf_rd_num0,
  output logic [4:0]                  wb2rf_rd_num1,
  output logic [4:0]                  wb2rf_rd_num2,
  output logic [4:0]                  wb2rf_rd_num3,
  output logic [31:0]                 wb2rf_rd_data0,
  output logic [31:0]                 wb2rf_rd_data1,
  output logic [31:0]                 wb2rf_rd_data2,
  output logic [31:0]                 wb2rf_rd_data3,
  output logic                        wb2rf_rd_we0,
  output logic                        wb2rf_rd_we1,
  output logic                        wb2rf_rd_we2,
  output logic                        wb2rf_rd_we3,
  output logic                        wb2rf_pred_we0,
  output logic                        wb2rf_pred_we1,
  output logic                        wb2rf_pred_we2,
  output logic                        wb2rf_pred_we3
);

  localparam logic [4:0] R31      = 5'd31;
  localparam logic [2:0] WAIT_MAX = 3'd4;

  // Lane-indexed view of the incoming bundle
  logic [4:0]  in_num  [4];
  logic [31:0] in_data [4];
  logic [3:0]  in_we;
  logic [3:0]  in_pwe;

  // Registered state
  logic [4:0]  out_num_q  [4];
  logic [4:0]  out_num_d  [4];
  logic [31:0] out_data_q [4];
  logic [31:0] out_data_d [4];
  logic [3:0]  out_we_q,  out_we_d;
  logic [3:0]  out_pwe_q, out_pwe_d;
  logic [4:0]  fifo_num_q  [2];
  logic [4:0]  fifo_num_d  [2];
  logic [31:0] fifo_data_q [2];
  logic [31:0] fifo_data_d [2];
  logic [1:0]  fifo_pred_q, fifo_pred_d;
  logic [1:0]  count_q, count_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;

  // Control
  logic stall;
  logic ready;
  logic v;
  logic lane3_free;
  logic push;
  logic pop;

  // Unpack the per-lane interface signals into arrays
  always_comb begin
    in_num[0]  = wb_if.mem2wb_rd_num0;
    in_num[1]  = wb_if.mem2wb_rd_num1;
    in_num[2]  = wb_if.mem2wb_rd_num2;
    in_num[3]  = wb_if.mem2wb_rd_num3;
    in_data[0] = wb_if.mem2wb_rd_data0;
    in_data[1] = wb_if.mem2wb_rd_data1;
    in_data[2] = wb_if.mem2wb_rd_data2;
    in_data[3] = wb_if.mem2wb_rd_data3;
    in_we      = {wb_if.mem2wb_rd_we3, wb_if.mem2wb_rd_we2,
                  wb_if.mem2wb_rd_we1, wb_if.mem2wb_rd_we0};
    in_pwe     = {wb_if.mem2wb_pred_we3, wb_if.mem2wb_pred_we2,
                  wb_if.mem2wb_pred_we1, wb_if.mem2wb_pred_we0};
  end

  // Handshake and arbitration; ready and stall depend on registered state only
  always_comb begin
    ready      = (count_q != 2'd2);
    stall      = (wait_cnt_q == WAIT_MAX);
    v          = wb_if.mem2wb_valid & ~stall;
    lane3_free = ~(v & (in_we[3] | in_pwe[3]));
    push       = wb_if.lr_valid & ready;
    pop        = (count_q != 2'd0) & lane3_free;
  end

  assign wb_if.lr_ready     = ready;
  assign wb_if.wb2mem_stall = stall;

  // Return FIFO next state; entry 0 is always the head
  always_comb begin
    fifo_num_d  = fifo_num_q;
    fifo_data_d = fifo_data_q;
    fifo_pred_d = fifo_pred_q;
    count_d     = count_q;
    if (push && pop) begin
      // Only reachable at count 1: the old head leaves, the new entry takes its place
      fifo_num_d[0]  = wb_if.lr_rd_num;
      fifo_data_d[0] = wb_if.lr_rd_data;
      fifo_pred_d[0] = wb_if.lr_pred;
    end else if (pop) begin
      fifo_num_d[0]  = fifo_num_q[1];
      fifo_data_d[0] = fifo_data_q[1];
      fifo_pred_d[0] = fifo_pred_q[1];
      count_d        = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) begin
        fifo_num_d[0]  = wb_if.lr_rd_num;
        fifo_data_d[0] = wb_if.lr_rd_data;
        fifo_pred_d[0] = wb_if.lr_pred;
      end else begin
        fifo_num_d[1]  = wb_if.lr_rd_num;
        fifo_data_d[1] = wb_if.lr_rd_data;
        fifo_pred_d[1] = wb_if.lr_pred;
      end
      count_d = count_q + 2'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Starvation counter: counts cycles a buffered head is denied lane 3
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (pop || (count_q == 2'd0)) begin
      wait_cnt_d = 3'd0;
    end else if (wait_cnt_q == WAIT_MAX) begin
      wait_cnt_d = WAIT_MAX;
    end else begin
      wait_cnt_d = wait_cnt_q + 3'd1;
    end
  end

  // Register-file write ports: bundle pass-through, lane 3 overridden by a pop
  always_comb begin
    out_num_d  = out_num_q;
    out_data_d = out_data_q;
    out_we_d   = 4'b0000;
    out_pwe_d  = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (v) begin
        out_num_d[k]  = in_num[k];
        out_data_d[k] = in_data[k];
        out_we_d[k]   = in_we[k] & (in_num[k] != R31);
        out_pwe_d[k]  = in_pwe[k];
      end else begin
        // Idle lane: hold num/data, enables already cleared
        out_we_d[k]  = 1'b0;
        out_pwe_d[k] = 1'b0;
      end
    end
    if (pop) begin
      out_num_d[3]  = fifo_num_q[0];
      out_data_d[3] = fifo_data_q[0];
      out_we_d[3]   = ~fifo_pred_q[0] & (fifo_num_q[0] != R31);
      out_pwe_d[3]  = fifo_pred_q[0];
    end else begin
      out_num_d[3] = out_num_d[3];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      for (int k = 0; k < 4; k++) begin
        out_num_q[k]  <= 5'd0;
        out_data_q[k] <= 32'd0;
      end
      for (int e = 0; e < 2; e++) begin
        fifo_num_q[e]  <= 5'd0;
        fifo_data_q[e] <= 32'd0;
      end
      out_we_q    <= 4'b0000;
      out_pwe_q   <= 4'b0000;
      fifo_pred_q <= 2'b00;
      count_q     <= 2'd0;
      wait_cnt_q  <= 3'd0;
    end else begin
      out_num_q   <= out_num_d;
      out_data_q  <= out_data_d;
      out_we_q    <= out_we_d;
      out_pwe_q   <= out_pwe_d;
      fifo_num_q  <= fifo_num_d;
      fifo_data_q <= fifo_data_d;
      fifo_pred_q <= fifo_pred_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign wb2rf_rd_num0  = out_num_q[0];
  assign wb2rf_rd_num1  = out_num_q[1];
  assign wb2rf_rd_num2  = out_num_q[2];
  assign wb2rf_rd_num3  = out_num_q[3];
  assign wb2rf_rd_data0 = out_data_q[0];
  assign wb2rf_rd_data1 = out_data_q[1];
  assign wb2rf_rd_data2 = out_data_q[2];
  assign wb2rf_rd_data3 = out_data_q[3];
  assign wb2rf_rd_we0   = out_we_q[0];
  assign wb2rf_rd_we1   = out_we_q[1];
  assign wb2rf_rd_we2   = out_we_q[2];
  assign wb2rf_rd_we3   = out_we_q[3];
  assign wb2rf_pred_we0 = out_pwe_q[0];
  assign wb2rf_pred_we1 = out_pwe_q[1];
  assign wb2rf_pred_we2 = out_pwe_q[2];
  assign wb2rf_pred_we3 = out_pwe_q[3];

endmodule

// File: tb/tb_mcpu_core_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mcpu_core_wb_stage
// Self-checking bench for mcpu_core_wb_stage: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_mcpu_core_wb_stage;

  logic clk;
  logic rst;

  // Stimulus, lane-indexed
  logic        d_valid;
  logic [4:0]  d_num  [4];
  logic [31:0] d_data [4];
  logic        d_we   [4];
  logic        d_pwe  [4];
  logic        l_valid;
  logic [4:0]  l_num;
  logic [31:0] l_data;
  logic        l_pred;

  // DUT outputs, lane-indexed
  logic [4:0]  o_num  [4];
  logic [31:0] o_data [4];
  logic        o_we   [4];
  logic        o_pwe  [4];
  logic        o_ready;
  logic        o_stall;

  // Reference model state
  typedef struct {
    logic [4:0]  num;
    logic [31:0] data;
    logic        pred;
  } ret_t;
  ret_t        ret_q[$];
  int          m_wait;
  logic [4:0]  e_num  [4];
  logic [31:0] e_data [4];
  logic        e_we   [4];
  logic        e_pwe  [4];

  int checks;
  int errors;

  mcpu_core_wb_stage_if bus_if ();

  assign bus_if.mem2wb_valid    = d_valid;
  assign bus_if.mem2wb_rd_num0  = d_num[0];
  assign bus_if.mem2wb_rd_num1  = d_num[1];
  assign bus_if.mem2wb_rd_num2  = d_num[2];
  assign bus_if.mem2wb_rd_num3  = d_num[3];
  assign bus_if.mem2wb_rd_data0 = d_data[0];
  assign bus_if.mem2wb_rd_data1 = d_data[1];
  assign bus_if.mem2wb_rd_data2 = d_data[2];
  assign bus_if.mem2wb_rd_data3 = d_data[3];
  assign bus_if.mem2wb_rd_we0   = d_we[0];
  assign bus_if.mem2wb_rd_we1   = d_we[1];
  assign bus_if.mem2wb_rd_we2   = d_we[2];
  assign bus_if.mem2wb_rd_we3   = d_we[3];
  assign bus_if.mem2wb_pred_we0 = d_pwe[0];
  assign bus_if.mem2wb_pred_we1 = d_pwe[1];
  assign bus_if.mem2wb_pred_we2 = d_pwe[2];
  assign bus_if.mem2wb_pred_we3 = d_pwe[3];
  assign bus_if.lr_valid        = l_valid;
  assign bus_if.lr_rd_num       = l_num;
  assign bus_if.lr_rd_data      = l_data;
  assign bus_if.lr_pred         = l_pred;
  assign o_ready                = bus_if.lr_ready;
  assign o_stall                = bus_if.wb2mem_stall;

  mcpu_core_wb_stage dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .wb_if           (bus_if.slave),
    .wb2rf_rd_num0   (o_num[0]),
    .wb2rf_rd_num1   (o_num[1]),
    .wb2rf_rd_num2   (o_num[2]),
    .wb2rf_rd_num3   (o_num[3]),
    .wb2rf_rd_data0  (o_data[0]),
    .wb2rf_rd_data1  (o_data[1]),
    .wb2rf_rd_data2  (o_data[2]),
    .wb2rf_rd_data3  (o_data[3]),
    .wb2rf_rd_we0    (o_we[0]),
    .wb2rf_rd_we1    (o_we[1]),
    .wb2rf_rd_we2    (o_we[2]),
    .wb2rf_rd_we3    (o_we[3]),
    .wb2rf_pred_we0  (o_pwe[0]),
    .wb2rf_pred_we1  (o_pwe[1]),
    .wb2rf_pred_we2  (o_pwe[2]),
    .wb2rf_pred_we3  (o_pwe[3])
  );

  // 100 MHz core clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    d_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d_num[k]  = 5'd0;
      d_data[k] = 32'd0;
      d_we[k]   = 1'b0;
      d_pwe[k]  = 1'b0;
    end
    l_valid = 1'b0;
    l_num   = 5'd0;
    l_data  = 32'd0;
    l_pred  = 1'b0;
  endtask

  // One clock: check handshake outputs, advance the model, clock, check wb2rf outputs
  task automatic step();
    bit   m_ready;
    bit   m_stall;
    bit   v;
    bit   busy3;
    ret_t h;
    ret_t n;
    m_ready = (ret_q.size() < 2);
    m_stall = (m_wait == 4);
    chk("lr_ready", {31'd0, o_ready}, {31'd0, m_ready});
    chk("stall", {31'd0, o_stall}, {31'd0, m_stall});
    if (rst) begin
      ret_q.delete();
      m_wait = 0;
      for (int k = 0; k < 4; k++) begin
        e_num[k] = 5'd0; e_data[k] = 32'd0; e_we[k] = 1'b0; e_pwe[k] = 1'b0;
      end
    end else begin
      v = d_valid && !m_stall;
      for (int k = 0; k < 4; k++) begin
        if (v) begin
          e_num[k]  = d_num[k];
          e_data[k] = d_data[k];
          e_we[k]   = d_we[k] && (d_num[k] != 5'd31);
          e_pwe[k]  = d_pwe[k];
        end else begin
          e_we[k]  = 1'b0;
          e_pwe[k] = 1'b0;
        end
      end
      busy3 = v && (d_we[3] || d_pwe[3]);
      if (ret_q.size() > 0 && !busy3) begin
        h = ret_q.pop_front();
        e_num[3]  = h.num;
        e_data[3] = h.data;
        e_we[3]   = !h.pred && (h.num != 5'd31);
        e_pwe[3]  = h.pred;
        m_wait    = 0;
      end else if (ret_q.size() == 0) begin
        m_wait = 0;
      end else begin
        m_wait = (m_wait < 4) ? m_wait + 1 : 4;
      end
      if (l_valid && m_ready) begin
        n.num = l_num; n.data = l_data; n.pred = l_pred;
        ret_q.push_back(n);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("num%0d", k),   {27'd0, o_num[k]}, {27'd0, e_num[k]});
      chk($sformatf("data%0d", k),  o_data[k], e_data[k]);
      chk($sformatf("we%0d", k),    {31'd0, o_we[k]},  {31'd0, e_we[k]});
      chk($sformatf("predwe%0d", k), {31'd0, o_pwe[k]}, {31'd0, e_pwe[k]});
    end
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    logic [31:0] seen[$];
    bit          accepted;
    checks = 0;
    errors = 0;
    m_wait = 0;
    for (int k = 0; k < 4; k++) begin
      e_num[k] = 5'd0; e_data[k] = 32'd0; e_we[k] = 1'b0; e_pwe[k] = 1'b0;
    end
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    rst = 1'b0;

    // Single lane-0 write
    d_valid = 1'b1; d_num[0] = 5'd5; d_data[0] = 32'hDEADBEEF; d_we[0] = 1'b1;
    step();
    chk("l0_we", {31'd0, o_we[0]}, 32'd1);
    chk("l0_num", {27'd0, o_num[0]}, 32'd5);
    chk("l0_data", o_data[0], 32'hDEADBEEF);
    chk("l1_we_idle", {31'd0, o_we[1]}, 32'd0);

    // r31 protection on lane 1; predicate write is not blocked
    idle_inputs();
    d_valid = 1'b1; d_num[1] = 5'd31; d_data[1] = 32'h11112222; d_we[1] = 1'b1;
    step();
    chk("r31_we1", {31'd0, o_we[1]}, 32'd0);
    d_we[1] = 1'b0; d_pwe[1] = 1'b1;
    step();
    chk("r31_pwe1", {31'd0, o_pwe[1]}, 32'd1);

    // Single return reaches lane 3 two cycles after offer
    idle_inputs();
    l_valid = 1'b1; l_num = 5'd7; l_data = 32'h00001234; l_pred = 1'b0;
    step();
    chk("lr_not_yet", {31'd0, o_we[3]}, 32'd0);
    idle_inputs();
    step();
    chk("lr_num3", {27'd0, o_num[3]}, 32'd7);
    chk("lr_data3", o_data[3], 32'h00001234);
    chk("lr_we3", {31'd0, o_we[3]}, 32'd1);
    step();

    // Three back-to-back returns while lane 3 is busy
    idle_inputs();
    seen.delete();
    d_valid = 1'b1; d_num[3] = 5'd20; d_data[3] = 32'hAAAA0000; d_we[3] = 1'b1;
    l_valid = 1'b1; l_num = 5'd10; l_pred = 1'b0;
    l_data = 32'd1;
    step();
    l_data = 32'd2;
    step();
    chk("ready_drop", {31'd0, o_ready}, 32'd0);
    l_data = 32'd3;
    accepted = 1'b0;
    for (int c = 0; c < 20 && !accepted; c++) begin
      accepted = o_ready;
      step();
      if (o_we[3] && o_num[3] == 5'd10) seen.push_back(o_data[3]);
    end
    chk("third_accepted", {31'd0, accepted}, 32'd1);
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      step();
      if (o_we[3] && o_num[3] == 5'd10) seen.push_back(o_data[3]);
    end
    chk("order_cnt", seen.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("order%0d", i), (i < seen.size()) ? seen[i] : 32'hFFFFFFFF, i + 1);
    end

    // Starvation: lane 3 written every cycle with one return buffered
    idle_inputs();
    l_valid = 1'b1; l_num = 5'd11; l_data = 32'h00000055; l_pred = 1'b0;
    step();
    idle_inputs();
    d_valid = 1'b1; d_num[3] = 5'd21; d_data[3] = 32'hBBBB0000; d_we[3] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("stall_early", {31'd0, o_stall}, 32'd0);
      step();
    end
    chk("stall_high", {31'd0, o_stall}, 32'd1);
    step();
    chk("stall_drop", {31'd0, o_stall}, 32'd0);
    chk("starve_num3", {27'd0, o_num[3]}, 32'd11);
    chk("starve_we3", {31'd0, o_we[3]}, 32'd1);
    step();

    // Reset with a full FIFO and stall asserted
    idle_inputs();
    d_valid = 1'b1; d_num[3] = 5'd22; d_data[3] = 32'hCCCC0000; d_we[3] = 1'b1;
    l_valid = 1'b1; l_num = 5'd12; l_data = 32'h12; l_pred = 1'b1;
    step();
    l_num = 5'd13; l_data = 32'h13; l_pred = 1'b0;
    step();
    l_valid = 1'b0;
    for (int c = 0; c < 10 && !o_stall; c++) step();
    chk("pre_rst_stall", {31'd0, o_stall}, 32'd1);
    chk("pre_rst_full", {31'd0, o_ready}, 32'd0);
    rst = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
    chk("post_rst_stall", {31'd0, o_stall}, 32'd0);
    chk("post_rst_data3", o_data[3], 32'd0);
    chk("post_rst_we3", {31'd0, o_we[3]}, 32'd0);
    rst = 1'b0;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      step();
      chk("no_stale_we3", {31'd0, o_we[3]}, 32'd0);
      chk("no_stale_pwe3", {31'd0, o_pwe[3]}, 32'd0);
    end

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      d_valid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) begin
        d_num[k]  = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        d_data[k] = $urandom;
        d_we[k]   = 1'($urandom_range(0, 1));
        d_pwe[k]  = ($urandom_range(0, 3) == 0);
      end
      // Bias lane 3 towards busy so the stall path is exercised often
      d_we[3]  = ($urandom_range(0, 4) != 0);
      l_valid  = ($urandom_range(0, 2) == 0);
      l_num    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      l_data   = $urandom;
      l_pred   = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
